// File: rtl/picorv32_mem_arbiter_pkg.sv
// rtl/picorv32_mem_arbiter_pkg.sv - shared types and constants for the picorv32 memory arbiter
package picorv32_mem_arbiter_pkg;

    // Transaction phases: waiting for a request, slave access in flight, master response
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    // Read data handed back to a master whose slave access was cut off by the watchdog
    localparam logic [31:0] TIMEOUT_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/picorv32_mem_arbiter_rr_arb2.sv
// rtl/picorv32_mem_arbiter_rr_arb2.sv - combinational two-way round-robin pick
module picorv32_mem_arbiter_rr_arb2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_grant,
    output logic o_gnt_valid,
    output logic o_gnt_idx
);

    // A lone requester always wins; on a tie the master not served last time wins
    always_comb begin
        o_gnt_valid = i_req0 | i_req1;
        if (i_req0 && i_req1) begin
            o_gnt_idx = ~i_last_grant;
        end else begin
            o_gnt_idx = i_req1;
        end
    end

endmodule

// File: rtl/picorv32_mem_arbiter.sv
// rtl/picorv32_mem_arbiter.sv - two-master round-robin arbiter for a picorv32-native memory port
module picorv32_mem_arbiter
    import picorv32_mem_arbiter_pkg::*;
#(
    parameter int unsigned  TIMEOUT_CYCLES = 256,
    parameter logic [31:0]  TIMEOUT_RDATA  = TIMEOUT_RDATA_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset,

    input  logic        i_m0_valid,
    input  logic        i_m0_instr,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_wdata,
    input  logic [3:0]  i_m0_wstrb,
    output logic        o_m0_ready,
    output logic [31:0] o_m0_rdata,

    input  logic        i_m1_valid,
    input  logic        i_m1_instr,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_wdata,
    input  logic [3:0]  i_m1_wstrb,
    output logic        o_m1_ready,
    output logic [31:0] o_m1_rdata,

    output logic        o_s_valid,
    output logic        o_s_instr,
    output logic [31:0] o_s_addr,
    output logic [31:0] o_s_wdata,
    output logic [3:0]  o_s_wstrb,
    input  logic        i_s_ready,
    input  logic [31:0] i_s_rdata,

    output logic        o_grant,
    output logic        o_timeout_err
);

    // A zero timeout disables the watchdog; keep the counter at least one bit wide anyway
    localparam bit              WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam int unsigned     WD_W    = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_EN ? WD_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [WD_W-1:0] WD_MAX  = '1;

    arb_state_t      r_state;
    logic            r_last_grant;
    logic [WD_W-1:0] r_wd;

    logic            w_gnt_valid;
    logic            w_gnt_idx;
    logic            w_sel_instr;
    logic [31:0]     w_sel_addr;
    logic [31:0]     w_sel_wdata;
    logic [3:0]      w_sel_wstrb;
    logic            w_wd_expire;
    logic            w_finish;
    logic [31:0]     w_resp_data;

    picorv32_mem_arbiter_rr_arb2 u_rr_arb2 (
        .i_req0       (i_m0_valid),
        .i_req1       (i_m1_valid),
        .i_last_grant (r_last_grant),
        .o_gnt_valid  (w_gnt_valid),
        .o_gnt_idx    (w_gnt_idx)
    );

    // Route the winning master's attributes and decide how the slave access ends
    always_comb begin
        w_sel_instr = w_gnt_idx ? i_m1_instr : i_m0_instr;
        w_sel_addr  = w_gnt_idx ? i_m1_addr  : i_m0_addr;
        w_sel_wdata = w_gnt_idx ? i_m1_wdata : i_m0_wdata;
        w_sel_wstrb = w_gnt_idx ? i_m1_wstrb : i_m0_wstrb;
        // s_ready takes priority over an expiry landing in the same cycle
        w_wd_expire = WD_EN && (r_wd == WD_LAST);
        w_finish    = i_s_ready || w_wd_expire;
        w_resp_data = i_s_ready ? i_s_rdata : TIMEOUT_RDATA;
    end

    // Watchdog: cleared while idle, counts slave cycles in BUSY, saturates instead of wrapping
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wd <= '0;
        end else if (r_state == ST_BUSY) begin
            if (r_wd != WD_MAX) begin
                r_wd <= r_wd + 1'b1;
            end
        end else begin
            r_wd <= '0;
        end
    end

    // Transaction FSM with registered slave request, master response and status outputs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_last_grant  <= 1'b1;
            o_s_valid     <= 1'b0;
            o_s_instr     <= 1'b0;
            o_s_addr      <= '0;
            o_s_wdata     <= '0;
            o_s_wstrb     <= '0;
            o_m0_ready    <= 1'b0;
            o_m0_rdata    <= '0;
            o_m1_ready    <= 1'b0;
            o_m1_rdata    <= '0;
            o_grant       <= 1'b0;
            o_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        o_s_valid    <= 1'b1;
                        o_s_instr    <= w_sel_instr;
                        o_s_addr     <= w_sel_addr;
                        o_s_wdata    <= w_sel_wdata;
                        o_s_wstrb    <= w_sel_wstrb;
                        o_grant      <= w_gnt_idx;
                        r_last_grant <= w_gnt_idx;
                        r_state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Master inputs are not looked at here; the registered copy stays on s_*
                    if (w_finish) begin
                        o_s_valid <= 1'b0;
                        if (!i_s_ready) begin
                            o_timeout_err <= 1'b1;
                        end
                        if (o_grant) begin
                            o_m1_ready <= 1'b1;
                            o_m1_rdata <= w_resp_data;
                        end else begin
                            o_m0_ready <= 1'b1;
                            o_m0_rdata <= w_resp_data;
                        end
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // One-cycle ready pulse; the following IDLE cycle lets the master drop valid
                    o_m0_ready <= 1'b0;
                    o_m1_ready <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// tb/tb_picorv32_mem_arbiter.sv - randomized self-checking bench for picorv32_mem_arbiter
module tb_picorv32_mem_arbiter;

    localparam int TMO = 8;

    logic        clk;
    logic        reset;
    logic        m0_valid, m0_instr, m0_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_valid, m1_instr, m1_ready;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        s_valid, s_instr, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        grant, timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: who was served last, sticky timeout flag
    int          m_last;
    bit          m_terr;
    logic [31:0] t_addr[2];
    logic [31:0] t_wdata[2];
    logic [3:0]  t_wstrb[2];
    logic        t_instr[2];

    picorv32_mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_m0_valid(m0_valid), .i_m0_instr(m0_instr), .i_m0_addr(m0_addr),
        .i_m0_wdata(m0_wdata), .i_m0_wstrb(m0_wstrb), .o_m0_ready(m0_ready), .o_m0_rdata(m0_rdata),
        .i_m1_valid(m1_valid), .i_m1_instr(m1_instr), .i_m1_addr(m1_addr),
        .i_m1_wdata(m1_wdata), .i_m1_wstrb(m1_wstrb), .o_m1_ready(m1_ready), .o_m1_rdata(m1_rdata),
        .o_s_valid(s_valid), .o_s_instr(s_instr), .o_s_addr(s_addr), .o_s_wdata(s_wdata),
        .o_s_wstrb(s_wstrb), .i_s_ready(s_ready), .i_s_rdata(s_rdata),
        .o_grant(grant), .o_timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic rand_attrs();
        for (int i = 0; i < 2; i++) begin
            t_addr[i]  = $urandom & 32'hFFFF_FFFC;
            t_wdata[i] = $urandom;
            t_wstrb[i] = 4'($urandom_range(0, 15));
            t_instr[i] = 1'($urandom_range(0, 1));
        end
    endtask

    // One transaction, started from an IDLE negedge; lat = BUSY cycles before s_ready (>= TMO: none)
    task automatic run_round(input bit v0, input bit v1, input int lat, input logic [31:0] sdata);
        int          g;
        bit          done;
        logic [31:0] erd;
        g = (v0 && v1) ? (1 - m_last) : (v1 ? 1 : 0);
        m_last = g;
        m0_valid = v0; m0_instr = t_instr[0]; m0_addr = t_addr[0]; m0_wdata = t_wdata[0]; m0_wstrb = t_wstrb[0];
        m1_valid = v1; m1_instr = t_instr[1]; m1_addr = t_addr[1]; m1_wdata = t_wdata[1]; m1_wstrb = t_wstrb[1];
        @(negedge clk);
        chk("grant", grant, g);
        // Changing master attributes mid-transaction must not disturb the slave request
        m0_addr = $urandom; m0_wdata = $urandom; m0_wstrb = 4'($urandom); m0_instr = ~m0_instr;
        m1_addr = $urandom; m1_wdata = $urandom; m1_wstrb = 4'($urandom); m1_instr = ~m1_instr;
        done = 1'b0;
        for (int c = 1; c <= TMO && !done; c++) begin
            chk("s_valid_busy", s_valid, 1);
            chk("s_addr", s_addr, t_addr[g]);
            chk("s_wdata", s_wdata, t_wdata[g]);
            chk("s_wstrb", s_wstrb, t_wstrb[g]);
            chk("s_instr", s_instr, t_instr[g]);
            chk("ready_early", {m1_ready, m0_ready}, 0);
            if (c == lat + 1) begin
                s_ready = 1'b1;
                s_rdata = sdata;
                done = 1'b1;
            end
            @(negedge clk);
            s_ready = 1'b0;
            s_rdata = $urandom;
        end
        if (!done) m_terr = 1'b1;
        erd = done ? sdata : 32'hDEAD_BEEF;
        chk("ready_resp", {m1_ready, m0_ready}, (g == 1) ? 2'b10 : 2'b01);
        chk("rdata", (g == 1) ? m1_rdata : m0_rdata, erd);
        chk("s_valid_resp", s_valid, 0);
        chk("timeout_err", timeout_err, m_terr);
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        // Stray slave ready outside BUSY must be ignored
        s_ready = 1'b1;
        @(negedge clk);
        s_ready = 1'b0;
        chk("ready_pulse_end", {m1_ready, m0_ready}, 0);
        chk("s_valid_idle", s_valid, 0);
    endtask

    initial begin
        reset = 1'b1;
        m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        s_ready = 0; s_rdata = 0;
        m_last = 1;
        m_terr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_s_valid", s_valid, 0);
        chk("rst_s_addr", s_addr, 0);
        chk("rst_s_wdata", s_wdata, 0);
        chk("rst_s_wstrb", s_wstrb, 0);
        chk("rst_ready", {m1_ready, m0_ready}, 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        chk("rst_m1_rdata", m1_rdata, 0);
        chk("rst_grant", grant, 0);
        chk("rst_timeout_err", timeout_err, 0);
        reset = 1'b0;
        @(negedge clk);

        // Both masters from reset: grants alternate starting with m0
        for (int i = 0; i < 4; i++) begin
            rand_attrs();
            run_round(1, 1, $urandom_range(0, 3), $urandom);
        end

        // Single m0 read, slave ready on its second BUSY cycle
        rand_attrs();
        t_addr[0] = 32'h100; t_wstrb[0] = 4'b0000;
        run_round(1, 0, 1, 32'h1234_5678);

        // m1 partial write
        rand_attrs();
        t_addr[1] = 32'h2000; t_wdata[1] = 32'hAABB_CCDD; t_wstrb[1] = 4'b0011;
        run_round(0, 1, 3, $urandom);

        // Slave ready exactly on the watchdog's last cycle
        rand_attrs();
        run_round(0, 1, TMO - 1, 32'h0BAD_F00D);

        // Slave never ready
        rand_attrs();
        run_round(1, 0, TMO, $urandom);

        // Random mix of requesters, latencies and timeouts
        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(1, 3);
            rand_attrs();
            run_round(r[0], r[1], $urandom_range(0, TMO + 1), $urandom);
        end

        // Reset in the middle of BUSY
        rand_attrs();
        m0_valid = 1'b1; m0_addr = t_addr[0]; m0_wdata = t_wdata[0]; m0_wstrb = t_wstrb[0];
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_s_valid", s_valid, 0);
        chk("arst_ready", {m1_ready, m0_ready}, 0);
        chk("arst_timeout_err", timeout_err, 0);
        chk("arst_grant", grant, 0);
        m0_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m_last = 1;
        m_terr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_ready = 1'b1;
            @(negedge clk);
            chk("post_rst_ready", {m1_ready, m0_ready}, 0);
            chk("post_rst_s_valid", s_valid, 0);
        end
        s_ready = 1'b0;
        rand_attrs();
        run_round(1, 1, 2, $urandom);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
